// File: rtl/ntt_pkg.sv
// Constants and helpers shared by the NTT input loader and the radix-8 stage.
// Coefficient width, modulus, butterfly mode encodings and 3-bit index reversal.
package ntt_pkg;

   localparam int WIDTH = 18;
   localparam int PRIME = 65537;

   typedef enum logic [1:0] {
      SEL_RADIX8 = 2'b00,
      SEL_RADIX4 = 2'b01,
      SEL_RADIX2 = 2'b10,
      SEL_RSVD   = 2'b11
   } select_mode_e;

   function automatic logic [2:0] bitrev3(input logic [2:0] idx);
      return {idx[0], idx[1], idx[2]};
   endfunction

endpackage

// File: rtl/mod_reduce_in.sv
// Combinational reduction of a raw coefficient into [0, PRIME) by subtracting
// the largest multiple k*PRIME (k = 0..3) that does not exceed it.
module mod_reduce_in #(
   parameter int WIDTH = 18,
   parameter int PRIME = 65537
) (
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] reduced
);

   // Compare at WIDTH+2 bits so multiples that exceed the input range never match.
   localparam logic [WIDTH+1:0] P1 = (WIDTH+2)'(PRIME);
   localparam logic [WIDTH+1:0] P2 = (WIDTH+2)'(2 * PRIME);
   localparam logic [WIDTH+1:0] P3 = (WIDTH+2)'(3 * PRIME);

   logic [WIDTH+1:0] ext;

   always_comb begin
      ext = {2'b00, value};
      if (ext >= P3) begin
         reduced = value - P3[WIDTH-1:0];
      end else if (ext >= P2) begin
         reduced = value - P2[WIDTH-1:0];
      end else if (ext >= P1) begin
         reduced = value - P1[WIDTH-1:0];
      end else begin
         reduced = value;
      end
   end

endmodule

// File: rtl/radix8_input_loader.sv
// Ping-pong loader: collects 8 reduced coefficients per block in natural order
// and presents them in bit-reversed butterfly order to the radix-8 stage.
module radix8_input_loader #(
   parameter int WIDTH = ntt_pkg::WIDTH,
   parameter int PRIME = ntt_pkg::PRIME
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_select_mode,
   input  logic             in_ntt_intt_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_1,
   output logic [WIDTH-1:0] out_2,
   output logic [WIDTH-1:0] out_3,
   output logic [WIDTH-1:0] out_4,
   output logic [WIDTH-1:0] out_5,
   output logic [WIDTH-1:0] out_6,
   output logic [WIDTH-1:0] out_7,
   output logic [WIDTH-1:0] out_8,
   output logic [1:0]       out_select_mode,
   output logic             out_ntt_intt_mode
);

   import ntt_pkg::*;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both 1; ready never depends on valid of the same channel.
   logic [WIDTH-1:0] bank [2][8];
   logic [1:0]       sel_q [2];
   logic [1:0]       ntt_q;
   logic [1:0]       full;
   logic [2:0]       wr_idx;
   logic             wr_bank;
   logic             rd_bank;
   logic [WIDTH-1:0] reduced;
   logic             accept;
   logic             consume;

   mod_reduce_in #(
      .WIDTH (WIDTH),
      .PRIME (PRIME)
   ) u_reduce (
      .value   (in_data),
      .reduced (reduced)
   );

   assign in_ready  = !rst && !full[wr_bank];
   assign out_valid = full[rd_bank];
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;

   // An accepting write bank is never full and a consumed read bank always is,
   // so the two updates below always touch different banks.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx  <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         full    <= '0;
         ntt_q   <= '0;
         for (int b = 0; b < 2; b++) begin
            sel_q[b] <= '0;
            for (int i = 0; i < 8; i++) begin
               bank[b][i] <= '0;
            end
         end
      end else begin
         if (accept) begin
            bank[wr_bank][wr_idx] <= reduced;
            if (wr_idx == 3'd0) begin
               sel_q[wr_bank] <= in_select_mode;
               ntt_q[wr_bank] <= in_ntt_intt_mode;
            end
            wr_idx <= wr_idx + 3'd1;
            if (wr_idx == 3'd7) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
            end
         end
         if (consume) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
      end
   end

   assign out_1 = bank[rd_bank][bitrev3(3'd0)];
   assign out_2 = bank[rd_bank][bitrev3(3'd1)];
   assign out_3 = bank[rd_bank][bitrev3(3'd2)];
   assign out_4 = bank[rd_bank][bitrev3(3'd3)];
   assign out_5 = bank[rd_bank][bitrev3(3'd4)];
   assign out_6 = bank[rd_bank][bitrev3(3'd5)];
   assign out_7 = bank[rd_bank][bitrev3(3'd6)];
   assign out_8 = bank[rd_bank][bitrev3(3'd7)];

   assign out_select_mode   = sel_q[rd_bank];
   assign out_ntt_intt_mode = ntt_q[rd_bank];

endmodule
